key_event_decoder: RTL
======================

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 Parameter LONG_CYC, default 100000, press duration in clk cycles that qualifies as a long press.
REQ-002 Parameter GAP_CYC, default 50000, maximum release gap in cycles between two presses of a double click.
REQ-003 Parameter REPEAT_CYC, default 20000, auto-repeat period in cycles while a long press is held.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 key  input  1  debounced key level from Key_Jitter, same clock domain; 1 = released, 0 = pressed.
REQ-007 click  output  1  one-cycle pulse, single click recognised.
REQ-008 dbl_click  output  1  one-cycle pulse, double click recognised.
REQ-009 long_press  output  1  one-cycle pulse, long press recognised.
REQ-010 repeat  output  1  one-cycle auto-repeat pulse; tied 0 when KEY_EVENT_REPEAT_EN is undefined.
REQ-011 led  output  4  event counter display.

Function
REQ-012 key SHALL be registered once; the FSM SHALL act on the registered level (one cycle of input latency).
REQ-013 FSM states SHALL be IDLE, DOWN1, UP_WAIT, DOWN2, HOLD; a single down-counter/up-counter cnt is cleared on every state change.
REQ-014 IDLE: key=0 -> DOWN1; otherwise stay.
REQ-015 DOWN1: key=1 with cnt < LONG_CYC-1 -> UP_WAIT; cnt == LONG_CYC-1 while key=0 -> HOLD and long_press pulse.
REQ-016 UP_WAIT: key=0 with cnt < GAP_CYC-1 -> DOWN2; cnt == GAP_CYC-1 with key=1 -> IDLE and click pulse.
REQ-017 DOWN2: key=1 -> IDLE and dbl_click pulse, regardless of how long the second press lasted.
REQ-018 HOLD: key=1 -> IDLE, no pulse; key=0 -> repeat behaviour per REQ-027.
REQ-019 Simultaneous press and timeout in the same cycle: the key event wins (UP_WAIT -> DOWN2; DOWN1 release on the final cycle -> UP_WAIT, no long_press).
REQ-020 All pulse outputs SHALL be registered, asserted exactly one cycle, and mutually exclusive in any cycle.
REQ-021 cnt width SHALL be $clog2 of the largest of LONG_CYC, GAP_CYC, REPEAT_CYC plus one; cnt saturates, never wraps.
REQ-022 led: +1 on click, -1 on dbl_click, cleared to 0 on long_press; modulo-16 wrap (15+1=0, 0-1=15); updated the cycle after the pulse.

Reset
REQ-023 rst=0 SHALL asynchronously force state IDLE, cnt 0, key register 1, all pulses 0, led 4'b0000.
REQ-024 Reset asserted mid-press SHALL discard the pending event; after release of reset a held key (key=0) SHALL start a fresh DOWN1.
REQ-025 Reset deassertion SHALL be treated as synchronous to clk by the upstream reset synchroniser.

Configuration
REQ-026 Macro KEY_EVENT_REPEAT_EN SHALL compile the auto-repeat feature in or out.
REQ-027 Defined: in HOLD, repeat pulses every REPEAT_CYC cycles while key=0, first pulse REPEAT_CYC cycles after long_press; repeat also increments led. Undefined: repeat=0, HOLD only waits for release, no repeat counter logic synthesised.

Structure
REQ-028 Shared package key_pkg SHALL hold the FSM state enum and the default cycle constants.
REQ-029 Sub-module key_led_counter (4-bit inc/dec/clear, wrap) SHALL implement the led register.

Verification (LONG_CYC=100, GAP_CYC=50, REPEAT_CYC=20)
REQ-030 Press 10 cycles, release, idle 60 -> one click 50 cycles after release, led 0->1.
REQ-031 Press 10, release 20, press 10, release -> one dbl_click on second release, no click; led 1->0.
REQ-032 Hold 250 cycles with REPEAT_EN -> long_press at cycle 100, repeat at 120,140,...,240 (7 pulses); led 0 then 7; without REPEAT_EN no repeat, led 0.
REQ-033 led=15 then click -> led 0; led=0 then dbl_click -> led 15.
REQ-034 Press 50 cycles, assert rst for 3 cycles, deassert with key held 100 -> no pulse during reset, outputs 0, long_press 100 cycles after restart.
REQ-035 Release at DOWN1 cycle 99 (boundary) -> no long_press; press at UP_WAIT cycle 49 -> DOWN2, no click.

Source files
------------

// File: rtl/key_pkg.sv
// Shared state encoding, default timing constants and a width helper
// for the key event decoder.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DOWN1   = 3'd1,
        UP_WAIT = 3'd2,
        DOWN2   = 3'd3,
        HOLD    = 3'd4
    } key_state_t;

    localparam int DEF_LONG_CYC   = 100000;
    localparam int DEF_GAP_CYC    = 50000;
    localparam int DEF_REPEAT_CYC = 20000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_led_counter.sv
// Four-bit event counter behind the led display: increment, decrement
// or clear, wrapping modulo 16.
module key_led_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    input  logic       clr,
    output logic [3:0] led
);

    logic [3:0] led_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_reg <= 4'd0;
        end else if (clr) begin
            led_reg <= 4'd0;
        end else if (inc) begin
            led_reg <= led_reg + 4'd1;
        end else if (dec) begin
            led_reg <= led_reg - 4'd1;
        end
    end

    assign led = led_reg;

endmodule

// File: rtl/key_event_decoder.sv
// Click / double-click / long-press decoder for a debounced active-low key.
// Define KEY_EVENT_REPEAT_EN to build in auto-repeat pulses while a long press is held.
module key_event_decoder
    import key_pkg::*;
#(
    parameter int LONG_CYC   = DEF_LONG_CYC,
    parameter int GAP_CYC    = DEF_GAP_CYC,
    parameter int REPEAT_CYC = DEF_REPEAT_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    output logic       click,
    output logic       dbl_click,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic [3:0] led
);

    localparam int CNT_W = $clog2(max3(LONG_CYC, GAP_CYC, REPEAT_CYC)) + 1;
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    key_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             key_reg;
    logic             click_reg, click_next;
    logic             dbl_reg, dbl_next;
    logic             long_reg, long_next;
    logic             rpt_hit;
    logic             rpt_out;

    // State register, phase counter, input register and registered pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            key_reg   <= 1'b1;
            click_reg <= 1'b0;
            dbl_reg   <= 1'b0;
            long_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            key_reg   <= key;
            click_reg <= click_next;
            dbl_reg   <= dbl_next;
            long_reg  <= long_next;
        end
    end

    // Next state: a key edge always takes precedence over a timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!key_reg) state_next = DOWN1;
            DOWN1: begin
                if (key_reg)                     state_next = UP_WAIT;
                else if (cnt_reg == LONG_LAST)   state_next = HOLD;
            end
            UP_WAIT: begin
                if (!key_reg)                    state_next = DOWN2;
                else if (cnt_reg == GAP_LAST)    state_next = IDLE;
            end
            DOWN2:   if (key_reg) state_next = IDLE;
            HOLD:    if (key_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if ((state_next != state_reg) || rpt_hit) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_MAX) begin
            cnt_next = cnt_reg;
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Pulse decode; at most one of these can be set for a given state.
    always_comb begin
        click_next = 1'b0;
        dbl_next   = 1'b0;
        long_next  = 1'b0;
        case (state_reg)
            DOWN1:   long_next  = !key_reg && (cnt_reg == LONG_LAST);
            UP_WAIT: click_next = key_reg && (cnt_reg == GAP_LAST);
            DOWN2:   dbl_next   = key_reg;
            default: ;
        endcase
    end

`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
    logic rpt_reg;

    // The shared counter restarts on every repeat so it also times the next period.
    assign rpt_hit = (state_reg == HOLD) && !key_reg && (cnt_reg == REPEAT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_reg <= 1'b0;
        end else begin
            rpt_reg <= rpt_hit;
        end
    end

    assign rpt_out = rpt_reg;
`else
    assign rpt_hit = 1'b0;
    assign rpt_out = 1'b0;
`endif

    key_led_counter u_led (
        .clk (clk),
        .rst (rst),
        .inc (click_reg | rpt_out),
        .dec (dbl_reg),
        .clr (long_reg),
        .led (led)
    );

    assign click        = click_reg;
    assign dbl_click    = dbl_reg;
    assign long_press   = long_reg;
    assign repeat_pulse = rpt_out;

endmodule
